// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared types and constants for the convolution sequencer.
//   conv_state_t : sequencer FSM states (IDLE, CLEAR, ACC, WRITE, DONE)
//   DEF_IMG_DIM / DEF_KER_DIM : default image and kernel side lengths
//   TAPS, OUT_DIM, PAD_OFF    : constants derived from the defaults
// Build option: CONV_SAME_PAD_EN selects same-size (zero padded) output.
package conv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACC,
      WRITE,
      DONE
   } conv_state_t;

   localparam int DEF_IMG_DIM = 4;
   localparam int DEF_KER_DIM = 3;

   function automatic int out_dim_of(input int img_dim, input int ker_dim);
`ifdef CONV_SAME_PAD_EN
      out_dim_of = img_dim + 0 * ker_dim;
`else
      out_dim_of = img_dim - ker_dim + 1;
`endif
   endfunction

   function automatic int pad_off_of(input int ker_dim);
      pad_off_of = (ker_dim - 1) / 2;
   endfunction

   localparam int TAPS    = DEF_KER_DIM * DEF_KER_DIM;
   localparam int OUT_DIM = out_dim_of(DEF_IMG_DIM, DEF_KER_DIM);
   localparam int PAD_OFF = pad_off_of(DEF_KER_DIM);

endpackage

// File: rtl/conv_idx_counter.sv
// conv_idx_counter: 2-D row-major index counter (col fastest).
//   clk, rst    : clock, synchronous active-low reset
//   clr         : return to (0,0)
//   en          : advance one position, wrapping to (0,0) after the last
//   row, col    : current position
//   wrap        : current position is the last one (ROWS-1, COLS-1)
module conv_idx_counter #(
   parameter int ROWS = 3,
   parameter int COLS = 3,
   parameter int W    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] row,
   output logic [W-1:0] col,
   output logic         wrap
);

   localparam logic [W-1:0] ROW_LAST = W'(ROWS - 1);
   localparam logic [W-1:0] COL_LAST = W'(COLS - 1);

   assign wrap = (row == ROW_LAST) && (col == COL_LAST);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the 8-bit convolution datapath.
// Walks every output position of a KER_DIM x KER_DIM kernel over an
// IMG_DIM x IMG_DIM image, driving operand selects and MAC strobes.
//   clk, rst            : clock, synchronous active-low reset
//   start               : begin a full pass (only honoured in IDLE)
//   hold                : stall tap stepping while accumulating
//   busy, done          : pass in progress / one-cycle end-of-pass pulse
//   mac_clr, mac_en     : accumulator clear / accumulate current tap
//   out_valid           : accumulator holds a finished output
//   a_row, a_col        : image operand select
//   b_row, b_col        : kernel operand select
//   use_zero            : select the zero register instead of the image
//   out_row, out_col    : output position being produced
// Build option: CONV_SAME_PAD_EN gives same-size output with zero padding;
// undefined gives valid-only convolution.
module conv_seq_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int IMG_DIM = DEF_IMG_DIM,
   parameter int KER_DIM = DEF_KER_DIM,
   parameter int IDX_W   = $clog2(IMG_DIM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             out_valid,
   output logic [IDX_W-1:0] a_row,
   output logic [IDX_W-1:0] a_col,
   output logic [IDX_W-1:0] b_row,
   output logic [IDX_W-1:0] b_col,
   output logic             use_zero,
   output logic [IDX_W-1:0] out_row,
   output logic [IDX_W-1:0] out_col
);

   localparam int N_OUT = out_dim_of(IMG_DIM, KER_DIM);

   conv_state_t      state;
   logic             last_tap;

   logic             tap_clr, tap_en, tap_wrap;
   logic [IDX_W-1:0] tap_row, tap_col;
   logic             pos_clr, pos_en, pos_wrap;
   logic [IDX_W-1:0] pos_row, pos_col;

   logic [IDX_W-1:0] sel_a_row, sel_a_col;
   logic             sel_zero;

   conv_idx_counter #(
      .ROWS (KER_DIM),
      .COLS (KER_DIM),
      .W    (IDX_W)
   ) u_tap_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (tap_clr),
      .en   (tap_en),
      .row  (tap_row),
      .col  (tap_col),
      .wrap (tap_wrap)
   );

   conv_idx_counter #(
      .ROWS (N_OUT),
      .COLS (N_OUT),
      .W    (IDX_W)
   ) u_pos_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (pos_clr),
      .en   (pos_en),
      .row  (pos_row),
      .col  (pos_col),
      .wrap (pos_wrap)
   );

   // The tap counter points at the next tap to issue. Taps are issued on
   // the CLEAR edge (tap 0) and on every unstalled ACC edge; the registered
   // strobe/selects then coincide in the following cycle.
   always_comb begin
      tap_clr = 1'b0;
      tap_en  = 1'b0;
      pos_clr = 1'b0;
      pos_en  = 1'b0;
      case (state)
         IDLE: begin
            pos_clr = start;
            tap_clr = start;
         end
         CLEAR: tap_en = 1'b1;
         ACC:   tap_en = !hold && !last_tap;
         WRITE: begin
            tap_clr = 1'b1;
            pos_en  = !pos_wrap;
         end
         default: ;
      endcase
   end

`ifdef CONV_SAME_PAD_EN
   localparam logic signed [IDX_W:0] PAD_S   = (IDX_W + 1)'(pad_off_of(KER_DIM));
   localparam logic signed [IDX_W:0] IMG_MAX = (IDX_W + 1)'(IMG_DIM - 1);

   logic signed [IDX_W:0] eff_row, eff_col;
   logic                  in_img;

   always_comb begin
      eff_row = $signed({1'b0, pos_row}) + $signed({1'b0, tap_row}) - PAD_S;
      eff_col = $signed({1'b0, pos_col}) + $signed({1'b0, tap_col}) - PAD_S;
      in_img  = !eff_row[IDX_W] && (eff_row <= IMG_MAX) &&
                !eff_col[IDX_W] && (eff_col <= IMG_MAX);
      sel_zero  = !in_img;
      sel_a_row = in_img ? eff_row[IDX_W-1:0] : '0;
      sel_a_col = in_img ? eff_col[IDX_W-1:0] : '0;
   end
`else
   always_comb begin
      sel_a_row = pos_row + tap_row;
      sel_a_col = pos_col + tap_col;
      sel_zero  = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         last_tap  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mac_clr   <= 1'b0;
         mac_en    <= 1'b0;
         out_valid <= 1'b0;
         a_row     <= '0;
         a_col     <= '0;
         b_row     <= '0;
         b_col     <= '0;
         use_zero  <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  mac_clr <= 1'b1;
                  out_row <= '0;
                  out_col <= '0;
               end
            end
            CLEAR: begin
               mac_clr <= 1'b0;
               state   <= ACC;
            end
            ACC: begin
               // A stall keeps the last issued selects on the bus.
               if (hold) begin
                  mac_en <= 1'b0;
               end else if (last_tap) begin
                  mac_en    <= 1'b0;
                  a_row     <= '0;
                  a_col     <= '0;
                  b_row     <= '0;
                  b_col     <= '0;
                  use_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               out_valid <= 1'b0;
               if (pos_wrap) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  mac_clr <= 1'b1;
                  state   <= CLEAR;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               out_row <= '0;
               out_col <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (tap_en) begin
            mac_en   <= 1'b1;
            out_row  <= pos_row;
            out_col  <= pos_col;
            b_row    <= tap_row;
            b_col    <= tap_col;
            a_row    <= sel_a_row;
            a_col    <= sel_a_col;
            use_zero <= sel_zero;
            last_tap <= tap_wrap;
         end
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: self-checking bench for conv_seq_ctrl.
// A reference model expands each pass into the expected strobe events
// (edge number, selects, accumulated result); a monitor pops and compares
// them whenever the DUT raises mac_clr, mac_en, out_valid or done.
// Honours CONV_SAME_PAD_EN in the same way as the design.
module tb_conv_seq_ctrl;

   localparam int IMG  = 4;
   localparam int KER  = 3;
   localparam int IW   = $clog2(IMG);
`ifdef CONV_SAME_PAD_EN
   localparam int OD   = IMG;
   localparam int OFF  = (KER - 1) / 2;
`else
   localparam int OD   = IMG - KER + 1;
   localparam int OFF  = 0;
`endif
   localparam int HMAX = 8192;

   localparam int K_CLR  = 1;
   localparam int K_TAP  = 2;
   localparam int K_OV   = 3;
   localparam int K_DONE = 4;

   typedef struct {
      int kind;
      int at;
      int orow, ocol, arow, acol, brow, bcol, uz, sum;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst, start, hold;
   logic          busy, done, mac_clr, mac_en, out_valid, use_zero;
   logic [IW-1:0] a_row, a_col, b_row, b_col, out_row, out_col;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];
   bit  hold_at [HMAX];
   int  A [IMG][IMG];
   int  B [KER][KER];
   int  acc = 0;

   conv_seq_ctrl #(
      .IMG_DIM (IMG),
      .KER_DIM (KER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .out_valid (out_valid),
      .a_row     (a_row),
      .a_col     (a_col),
      .b_row     (b_row),
      .b_col     (b_col),
      .use_zero  (use_zero),
      .out_row   (out_row),
      .out_col   (out_col)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endfunction

   function automatic int all_outs();
      return int'({busy, done, mac_clr, mac_en, out_valid, use_zero,
                   a_row, a_col, b_row, b_col, out_row, out_col});
   endfunction

   function automatic void push_ev(input int kind, input int at, input int orow, input int ocol,
                                   input int arow, input int acol, input int brow, input int bcol,
                                   input int uz, input int sum);
      ev_t e;
      e = '{kind:kind, at:at, orow:orow, ocol:ocol, arow:arow, acol:acol,
            brow:brow, bcol:bcol, uz:uz, sum:sum};
      exp_q.push_back(e);
   endfunction

   // Reference: one output = clear cycle, KER*KER taps, write cycle. A hold
   // seen on the edge that consumed a tap (or on a stall edge) delays the
   // next step by one cycle. Returns the first edge that sees busy low.
   function automatic int build_pass(input int s);
      int t, nxt, r, c, sum, orow, ocol, kr, kc;
      bit inr;
      t = s + 1;
      for (int o = 0; o < OD * OD; o++) begin
         orow = o / OD;
         ocol = o % OD;
         push_ev(K_CLR, t, 0, 0, 0, 0, 0, 0, 0, 0);
         t++;
         sum = 0;
         for (int k = 0; k < KER * KER; k++) begin
            kr  = k / KER;
            kc  = k % KER;
            r   = orow + kr - OFF;
            c   = ocol + kc - OFF;
            inr = (r >= 0) && (r < IMG) && (c >= 0) && (c < IMG);
            if (inr) sum += A[r][c] * B[kr][kc];
            push_ev(K_TAP, t, orow, ocol, inr ? r : 0, inr ? c : 0, kr, kc, inr ? 0 : 1, 0);
            nxt = t + 1;
            while (nxt < HMAX - 1 && hold_at[nxt-1]) nxt++;
            t = nxt;
         end
         push_ev(K_OV, t, orow, ocol, 0, 0, 0, 0, 0, sum);
         t++;
      end
      push_ev(K_DONE, t, 0, 0, 0, 0, 0, 0, 0, 0);
      return t + 1;
   endfunction

   function automatic void prune(input int lim);
      ev_t keep[$];
      foreach (exp_q[i]) if (exp_q[i].at <= lim) keep.push_back(exp_q[i]);
      exp_q = keep;
   endfunction

   // Monitor plus behavioural MAC; outputs seen here are sampled at edge cyc.
   int  mon_kind, mon_n;
   ev_t mon_e;
   always @(negedge clk) begin
      if (mac_clr || mac_en || out_valid || done) begin
         mon_n    = int'(mac_clr) + int'(mac_en) + int'(out_valid) + int'(done);
         mon_kind = (mon_n > 1) ? 9 : mac_clr ? K_CLR : mac_en ? K_TAP : out_valid ? K_OV : K_DONE;
         if (exp_q.size() == 0) begin
            chk("spurious_strobe", mon_kind, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("strobe_kind", mon_kind, mon_e.kind);
            chk("strobe_edge", cyc, mon_e.at);
            chk("busy_in_pass", int'(busy), 1);
            if (mon_e.kind == K_TAP) begin
               chk("tap_out_row", int'(out_row), mon_e.orow);
               chk("tap_out_col", int'(out_col), mon_e.ocol);
               chk("tap_a_row", int'(a_row), mon_e.arow);
               chk("tap_a_col", int'(a_col), mon_e.acol);
               chk("tap_b_row", int'(b_row), mon_e.brow);
               chk("tap_b_col", int'(b_col), mon_e.bcol);
               chk("tap_use_zero", int'(use_zero), mon_e.uz);
            end else begin
               chk("idle_selects", int'({a_row, a_col, b_row, b_col, use_zero}), 0);
               if (mon_e.kind == K_OV) begin
                  chk("ov_out_row", int'(out_row), mon_e.orow);
                  chk("ov_out_col", int'(out_col), mon_e.ocol);
                  chk("ov_result", acc, mon_e.sum);
               end
            end
         end
         if (mac_clr) acc = 0;
         if (mac_en && !use_zero) acc += A[a_row][a_col] * B[b_row][b_col];
      end
   end

   // hold_mode: 0 none, 1 three cycles at tap 4 of first output, 2 random.
   // extra_start / rst_at: offsets from the start edge, -1 for none.
   task automatic run_pass(input int hold_mode, input int extra_start, input int rst_at,
                           input bit rand_bank);
      int s, stop;
      @(negedge clk);
      s = cyc;
      for (int i = s; i < s + 900 && i < HMAX; i++)
         hold_at[i] = (hold_mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (hold_mode == 1) begin
         hold_at[s+6] = 1'b1;
         hold_at[s+7] = 1'b1;
         hold_at[s+8] = 1'b1;
      end
      if (rand_bank) begin
         for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++) A[r][c] = int'($urandom_range(0, 255));
         for (int r = 0; r < KER; r++)
            for (int c = 0; c < KER; c++) B[r][c] = int'($urandom_range(0, 255));
      end
      stop = build_pass(s);
      if (rst_at >= 0) begin
         prune(s + rst_at);
         stop = s + rst_at + 1;
      end
      while (cyc < stop) begin
         start = (cyc == s) || (extra_start >= 0 && cyc == s + extra_start);
         hold  = hold_at[cyc];
         rst   = !(rst_at >= 0 && cyc == s + rst_at);
         if (cyc == s + 1 && rst_at != 0) chk("busy_after_start", int'(busy), 1);
         @(negedge clk);
      end
      start = 1'b0;
      hold  = 1'b0;
      rst   = 1'b1;
      if (rst_at >= 0) chk("outs_after_reset", all_outs(), 0);
      else             chk("busy_low_at_end", int'(busy), 0);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int a_row0 [4];
      int b_def [9];
      a_row0 = '{9, 1, 10, 5};
      b_def  = '{2, 5, 5, 5, 3, 5, 4, 0, 4};
      for (int r = 0; r < IMG; r++)
         for (int c = 0; c < IMG; c++)
            A[r][c] = (r == 0) ? a_row0[c] : int'($urandom_range(0, 255));
      for (int k = 0; k < KER * KER; k++) B[k / KER][k % KER] = b_def[k];

      rst   = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_outputs", all_outs(), 0);

      run_pass(0, -1, -1, 1'b0);   // plain pass, default bank
      run_pass(1, -1, -1, 1'b0);   // hold at tap 4
      run_pass(2, -1, -1, 1'b1);   // random holds, random bank
      run_pass(0, 20, -1, 1'b1);   // start while busy is ignored
      run_pass(0, -1, 15, 1'b0);   // reset mid-pass
      run_pass(0, -1, -1, 1'b0);   // fresh pass after reset
      run_pass(0, -1, 0, 1'b0);    // start and reset together
      repeat (3) @(negedge clk);
      chk("no_pass_after_reset_start", int'(busy), 0);
      run_pass(2, -1, -1, 1'b1);
      run_pass(2, 7, -1, 1'b1);

      repeat (3) @(negedge clk);
      chk("final_idle", all_outs(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencer for the 8-bit convolution datapath. It walks the output positions of a KER_DIM×KER_DIM kernel over an IMG_DIM×IMG_DIM image. For each tap it drives row/column selects into the operand register bank (image A, kernel B, zero register) and issues clear/enable/valid strobes to the downstream multiply-accumulate unit. It sits between the operand register bank and the MAC/result stage and owns the start/done handshake with the top level.

## Interface
- IMG_DIM, 4, image side length (rows = cols)
- KER_DIM, 3, kernel side length; must be ≤ IMG_DIM
- IDX_W, $clog2(IMG_DIM), width of every row/column index
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request a full convolution pass; sampled only in IDLE
- hold  in  1  stalls tap stepping in ACC
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate current tap
- out_valid  out  1  accumulator holds a finished output
- a_row, a_col  out  IDX_W  image operand select
- b_row, b_col  out  IDX_W  kernel operand select
- use_zero  out  1  select zero register instead of image operand
- out_row, out_col  out  IDX_W  output position currently being produced

## Operation
- All outputs are registered. Reset value of every output is 0. Reset drives the FSM to IDLE from any state, mid-pass included. A pass interrupted by reset is discarded, with no done pulse.
- FSM states:
  - IDLE: start=1 → CLEAR. Clears the output-position counters.
  - CLEAR: mac_clr=1 for one cycle → ACC. Tap counters (kr,kc) cleared.
  - ACC: mac_en=1, one tap per cycle, row-major (kc fastest). hold=1 freezes the counters and forces mac_en=0. The last tap (KER_DIM-1, KER_DIM-1) is consumed with hold=0 → WRITE.
  - WRITE: out_valid=1 for one cycle, with out_row/out_col naming the position. If this is the last position → DONE; otherwise the position advances row-major (out_col fastest) → CLEAR.
  - DONE: done=1 for one cycle → IDLE.
- Selects during ACC:
  - b_row=kr, b_col=kc.
  - a_row=out_row+kr, a_col=out_col+kc, in IDX_W unsigned arithmetic with no wrap possible.
- Outside ACC, all selects are 0 and use_zero=0.
- start while busy is ignored, not queued. hold outside ACC has no effect.
- start and rst low in the same cycle: reset wins.

## Timing
- The edge that samples start is edge 0. CLEAR is at edge 1. Taps occupy edges 2..KER_DIM²+1 when hold is never raised.
- One output costs 2+KER_DIM² cycles: 11 at defaults. Each hold cycle in ACC adds exactly one cycle.
- Defaults without padding give 4 outputs: out_valid at edges 11, 22, 33, 44, done at edge 45, IDLE (busy=0) at edge 46.
- Strobes are coincident with the selects they qualify. The MAC samples operands on the same edge on which mac_en is high.

## Configuration
- CONV_SAME_PAD_EN defined:
  - Same-size output. Output grid is IMG_DIM×IMG_DIM (16 positions at defaults).
  - Effective image coordinate is out_row+kr-(KER_DIM-1)/2, computed signed, one bit wider than IDX_W.
  - If either coordinate lies outside 0..IMG_DIM-1: use_zero=1 and a_row=a_col=0. Otherwise use_zero=0 and a_row/a_col carry the coordinate.
  - Last done at edge 177 at defaults.
- Undefined: valid-only convolution. Output grid is (IMG_DIM-KER_DIM+1)², use_zero is tied 0, and no signed path is synthesized.

## Structure
- Shared package conv_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, ACC, WRITE, DONE)
  - default IMG_DIM/KER_DIM
  - derived constants TAPS=KER_DIM², OUT_DIM, PAD_OFF=(KER_DIM-1)/2
- One sub-module, conv_idx_counter: a 2-D row-major counter with clear, enable, and a wrap flag. It is instantiated twice: once for taps, once for output positions.

## Test plan
- Reset, then start pulse, no hold → out_valid at edges 11/22/33/44 with (out_row,out_col)=(0,0),(0,1),(1,0),(1,1). done at edge 45, busy low at edge 46.
- Tap trace for output (1,1) → a selects step (1,1)…(3,3) and b selects step (0,0)…(2,2), row-major. With bank defaults (A row0=9,1,10,5…; B=2,5,5/5,3,5/4,0,4) and a behavioural MAC, output (0,0) = 263.
- hold=1 for 3 cycles at tap 4 of the first output → mac_en low for those 3 cycles, tap 4 selects held, first out_valid moves to edge 14.
- start pulsed at edge 20 while busy → no effect: same done edge as a single pass.
- rst low at edge 15 → all outputs 0 at edge 16, no done. A fresh start then completes a normal 45-cycle pass.
- CONV_SAME_PAD_EN, output (0,0) → use_zero=1 on taps 0,1,2,3,6. Tap 4 gives a=(0,0), b=(1,1). 16 out_valid pulses, done at edge 177.
